// File: rtl/tlp_xcvr_pkg.sv
// Shared types for the PCIe TLP transmit path.
// Source indices, arbiter states and the 64-bit beat type.
package tlp_xcvr_pkg;

   localparam int DEF_NUM_SRC = 3;
   localparam int SRC_CPL     = 0;

   typedef logic [63:0] uint64;
   typedef logic [$clog2(DEF_NUM_SRC)-1:0] SrcIndex;

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } ArbState;

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority encoder: first set bit of req at or after start,
// wrapping around; found is low when req is empty.
module rr_pick #(
   parameter int N = 3,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic [W-1:0] idx,
   output logic         found
);

   int j;

   // Walk from the far end back so the nearest hit is written last.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(start) + k) % N;
         if (req[j]) begin
            idx   = W'(j);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tlp_tx_arbiter.sv
// Packet-atomic arbiter for the shared PCIe TX stream: source 0 has
// priority (bounded by a streak guard), the rest are round-robin.
module tlp_tx_arbiter
   import tlp_xcvr_pkg::*;
#(
   parameter int NUM_SRC        = 3,
   parameter int CPL_STREAK_MAX = 4
) (
   input  logic                       pcieClk_in,
   input  logic                       reset_in,
   input  logic [NUM_SRC*64-1:0]      srcData_in,
   input  logic [NUM_SRC-1:0]         srcValid_in,
   output logic [NUM_SRC-1:0]         srcReady_out,
   input  logic [NUM_SRC-1:0]         srcSOP_in,
   input  logic [NUM_SRC-1:0]         srcEOP_in,
   output logic [63:0]                txData_out,
   output logic                       txValid_out,
   input  logic                       txReady_in,
   output logic                       txSOP_out,
   output logic                       txEOP_out,
   output logic [$clog2(NUM_SRC)-1:0] grant_out,
   output logic                       busy_out,
   output logic                       protoErr_out
);

   localparam int W = $clog2(NUM_SRC);
   localparam logic [W-1:0] LAST = W'(NUM_SRC - 1);
   localparam logic [W-1:0] CPL  = W'(SRC_CPL);
   localparam logic [3:0]   SMAX = 4'(CPL_STREAK_MAX);

   ArbState state, stateNext;
   logic [W-1:0] grant, grantNext;
   logic [W-1:0] rrPtr, rrPtrNext;
   logic [W-1:0] rrIdx;
   logic [3:0] streak, streakNext;
   logic protoErr, protoErrNext;
   logic firstBeat, firstBeatNext;
   logic sawOther, sawOtherNext;
   logic rrFound;

   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] rrReq;
   logic otherReq, noSop, pick0;
   logic hs, eopHs;
   uint64 beat;

   assign req      = srcValid_in & srcSOP_in;
   assign rrReq    = {req[NUM_SRC-1:1], 1'b0};
   assign otherReq = |rrReq;
   assign noSop    = |(srcValid_in & ~srcSOP_in);
   assign pick0    = req[SRC_CPL] & ((streak < SMAX) | ~otherReq);

   rr_pick #(.N(NUM_SRC), .W(W)) uPick (
      .req   (rrReq),
      .start (rrPtr),
      .idx   (rrIdx),
      .found (rrFound)
   );

   assign beat = srcData_in[int'(grant)*64 +: 64];

   always_comb begin
      txData_out   = '0;
      txValid_out  = 1'b0;
      txSOP_out    = 1'b0;
      txEOP_out    = 1'b0;
      srcReady_out = '0;
      if (state == S_BUSY) begin
         txData_out          = beat;
         txValid_out         = srcValid_in[grant];
         txSOP_out           = srcSOP_in[grant];
         txEOP_out           = srcEOP_in[grant];
         srcReady_out[grant] = txReady_in;
      end
   end

   assign hs           = txValid_out & txReady_in;
   assign eopHs        = hs & txEOP_out;
   assign grant_out    = grant;
   assign busy_out     = (state == S_BUSY);
   assign protoErr_out = protoErr;

   always_comb begin
      stateNext     = state;
      grantNext     = grant;
      rrPtrNext     = rrPtr;
      streakNext    = streak;
      protoErrNext  = protoErr;
      firstBeatNext = firstBeat;
      sawOtherNext  = sawOther;
      unique case (state)
         S_IDLE: begin
            if (noSop) protoErrNext = 1'b1;
            if (pick0 || rrFound) begin
               stateNext     = S_BUSY;
               grantNext     = pick0 ? CPL : rrIdx;
               firstBeatNext = 1'b1;
               sawOtherNext  = otherReq;
            end
         end
         S_BUSY: begin
            sawOtherNext = sawOther | otherReq;
            if (hs) begin
               firstBeatNext = 1'b0;
               if (txSOP_out && !firstBeat) protoErrNext = 1'b1;
            end
            if (eopHs) begin
               stateNext = S_IDLE;
               if (grant == CPL) begin
                  if (sawOther | otherReq)
                     streakNext = (streak < SMAX) ? streak + 4'd1 : streak;
                  else
                     streakNext = '0;
               end else begin
                  streakNext = '0;
                  rrPtrNext  = (grant == LAST) ? W'(1) : grant + 1'b1;
               end
            end
         end
         default: stateNext = S_IDLE;
      endcase
   end

   always_ff @(posedge pcieClk_in) begin
      if (reset_in) begin
         state     <= S_IDLE;
         grant     <= '0;
         rrPtr     <= W'(1);
         streak    <= '0;
         protoErr  <= 1'b0;
         firstBeat <= 1'b0;
         sawOther  <= 1'b0;
      end else begin
         state     <= stateNext;
         grant     <= grantNext;
         rrPtr     <= rrPtrNext;
         streak    <= streakNext;
         protoErr  <= protoErrNext;
         firstBeat <= firstBeatNext;
         sawOther  <= sawOtherNext;
      end
   end

endmodule
